vip_ycbcr2rgb: RTL and testbench

VIP_YCBCR2RGB -- requirements
Module: vip_ycbcr2rgb

---
 rtl/vip_color_pkg.sv | 51 +++++
 rtl/vip_ycbcr2rgb_if.sv | 29 ++
 rtl/vip_ycbcr2rgb.sv | 125 ++++++++++++
 tb/tb_vip_ycbcr2rgb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vip_color_pkg.sv
// Shared colour-space constants and helpers for the video IP blocks.
// Holds both BT.601 coefficient sets (full range and limited range), the
// Q8 rounding constant and shift, and the unsigned 8-bit clip function.
package vip_color_pkg;

    // Q8 fixed-point rounding: add half an LSB, then shift right by 8.
    localparam int unsigned         Q_SHIFT = 8;
    localparam logic signed [19:0]  Q_ROUND = 20'sd128;

    // Full-range BT.601 (Y scaled by 256, offsets about 128).
    localparam int FR_Y_OFS = 0;
    localparam int FR_K_Y   = 256;
    localparam int FR_K_RV  = 359;
    localparam int FR_K_GU  = 88;
    localparam int FR_K_GV  = 183;
    localparam int FR_K_BU  = 454;

    // Limited-range BT.601 (Y 16..235, chroma 16..240).
    localparam int LR_Y_OFS = 16;
    localparam int LR_K_Y   = 298;
    localparam int LR_K_RV  = 409;
    localparam int LR_K_GU  = 100;
    localparam int LR_K_GV  = 208;
    localparam int LR_K_BU  = 517;

    // Widths used through the conversion pipeline.
    typedef logic signed [8:0]  ofs_t;
    typedef logic signed [10:0] coef_t;
    typedef logic signed [17:0] prod_t;
    typedef logic signed [19:0] sum_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Clamp a signed intermediate into 0..255.
    function automatic logic [7:0] clip_u8(input sum_t v);
        logic [7:0] res;
        if (v < 0) begin
            res = 8'd0;
        end else if (v > 20'sd255) begin
            res = 8'd255;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/vip_ycbcr2rgb_if.sv
// Pixel stream interface for vip_ycbcr2rgb: YCbCr in with frame/line syncs,
// RGB888 out with the syncs delayed to match.
interface vip_ycbcr2rgb_if;

    logic       per_img_vsync;
    logic       per_img_href;
    logic [7:0] per_img_y;
    logic [7:0] per_img_cb;
    logic [7:0] per_img_cr;

    logic       post_img_vsync;
    logic       post_img_href;
    logic [7:0] post_img_red;
    logic [7:0] post_img_green;
    logic [7:0] post_img_blue;

    // Source side: drives YCbCr, observes RGB.
    modport master (
        output per_img_vsync, per_img_href, per_img_y, per_img_cb, per_img_cr,
        input  post_img_vsync, post_img_href, post_img_red, post_img_green, post_img_blue
    );

    // Converter side.
    modport slave (
        input  per_img_vsync, per_img_href, per_img_y, per_img_cb, per_img_cr,
        output post_img_vsync, post_img_href, post_img_red, post_img_green, post_img_blue
    );

endinterface

// File: rtl/vip_ycbcr2rgb.sv
// BT.601 YCbCr 4:4:4 to RGB888 converter, three registered stages, no stalls.
//   S1: remove offsets (Cb-128, Cr-128, and Y-16 in limited range)
//   S2: register all coefficient products
//   S3: sum, round, >>8, saturate, optionally blank outside href
// Build option: define YCBCR2RGB_LIMITED_RANGE_EN for limited-range
// (16-235 / 16-240) input; otherwise full-range coefficients are used.
module vip_ycbcr2rgb
    import vip_color_pkg::*;
#(
    parameter bit BLANK_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    vip_ycbcr2rgb_if.slave    vif
);

`ifdef YCBCR2RGB_LIMITED_RANGE_EN
    localparam int Y_OFS = LR_Y_OFS;
    localparam int K_Y   = LR_K_Y;
    localparam int K_RV  = LR_K_RV;
    localparam int K_GU  = LR_K_GU;
    localparam int K_GV  = LR_K_GV;
    localparam int K_BU  = LR_K_BU;
`else
    localparam int Y_OFS = FR_Y_OFS;
    localparam int K_Y   = FR_K_Y;
    localparam int K_RV  = FR_K_RV;
    localparam int K_GU  = FR_K_GU;
    localparam int K_GV  = FR_K_GV;
    localparam int K_BU  = FR_K_BU;
`endif

    localparam coef_t C_Y  = coef_t'(K_Y);
    localparam coef_t C_RV = coef_t'(K_RV);
    localparam coef_t C_GU = coef_t'(K_GU);
    localparam coef_t C_GV = coef_t'(K_GV);
    localparam coef_t C_BU = coef_t'(K_BU);
    localparam logic [8:0] Y_OFS_9 = 9'(Y_OFS);

    // Stage 1 registers
    ofs_t  y_s1, cb_s1, cr_s1;
    // Stage 2 registers
    prod_t p_y_s2, p_rv_s2, p_gu_s2, p_gv_s2, p_bu_s2;
    // Stage 3 registers
    rgb_t  rgb_s3;
    // Sync delay lines, bit 2 is the output stage
    logic [2:0] vs_sr, hs_sr;

    sum_t sum_r, sum_g, sum_b;
    sum_t shr_r, shr_g, shr_b;
    logic blank;

    // S1: strip the offsets; the pipeline runs every cycle independent of href.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s1  <= '0;
            cb_s1 <= '0;
            cr_s1 <= '0;
        end else begin
            y_s1  <= $signed({1'b0, vif.per_img_y}  - Y_OFS_9);
            cb_s1 <= $signed({1'b0, vif.per_img_cb} - 9'd128);
            cr_s1 <= $signed({1'b0, vif.per_img_cr} - 9'd128);
        end
    end

    // S2: coefficient products, signed 18 bits covers the worst case of both ranges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_y_s2  <= '0;
            p_rv_s2 <= '0;
            p_gu_s2 <= '0;
            p_gv_s2 <= '0;
            p_bu_s2 <= '0;
        end else begin
            p_y_s2  <= prod_t'(y_s1)  * prod_t'(C_Y);
            p_rv_s2 <= prod_t'(cr_s1) * prod_t'(C_RV);
            p_gu_s2 <= prod_t'(cb_s1) * prod_t'(C_GU);
            p_gv_s2 <= prod_t'(cr_s1) * prod_t'(C_GV);
            p_bu_s2 <= prod_t'(cb_s1) * prod_t'(C_BU);
        end
    end

    // S3 arithmetic: sign-extended 20-bit sums cannot wrap for any 8-bit input.
    always_comb begin
        sum_r = sum_t'(p_y_s2) + sum_t'(p_rv_s2) + Q_ROUND;
        sum_g = sum_t'(p_y_s2) - sum_t'(p_gu_s2) - sum_t'(p_gv_s2) + Q_ROUND;
        sum_b = sum_t'(p_y_s2) + sum_t'(p_bu_s2) + Q_ROUND;
        shr_r = sum_r >>> Q_SHIFT;
        shr_g = sum_g >>> Q_SHIFT;
        shr_b = sum_b >>> Q_SHIFT;
        // hs_sr[1] is the href that lands in the output stage with this data.
        blank = BLANK_ZERO && !hs_sr[1];
    end

    // S3: saturate and register the RGB result, zeroed during blanking if enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_s3 <= '0;
        end else if (blank) begin
            rgb_s3 <= '0;
        end else begin
            rgb_s3.r <= clip_u8(shr_r);
            rgb_s3.g <= clip_u8(shr_g);
            rgb_s3.b <= clip_u8(shr_b);
        end
    end

    // Syncs ride a 3-deep shift register so they stay aligned with S3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sr <= '0;
            hs_sr <= '0;
        end else begin
            vs_sr <= {vs_sr[1:0], vif.per_img_vsync};
            hs_sr <= {hs_sr[1:0], vif.per_img_href};
        end
    end

    assign vif.post_img_vsync = vs_sr[2];
    assign vif.post_img_href  = hs_sr[2];
    assign vif.post_img_red   = rgb_s3.r;
    assign vif.post_img_green = rgb_s3.g;
    assign vif.post_img_blue  = rgb_s3.b;

endmodule

// File: tb/tb_vip_ycbcr2rgb.sv
// Self-checking bench for vip_ycbcr2rgb (default BLANK_ZERO=1).
// Honours YCBCR2RGB_LIMITED_RANGE_EN for the expected-value model and table.
module tb_vip_ycbcr2rgb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vip_ycbcr2rgb_if vif();

    vip_ycbcr2rgb #(.BLANK_ZERO(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vs;
        logic       hs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    exp_t q[$];
    vec_t vt[5];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [7:0] clamp(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // Reference conversion in plain integer arithmetic.
    function automatic logic [23:0] conv(input logic [7:0] y, cb, cr);
        int yy, u, v, r, g, b;
        u = int'(cb) - 128;
        v = int'(cr) - 128;
`ifdef YCBCR2RGB_LIMITED_RANGE_EN
        yy = 298 * (int'(y) - 16);
        r = (yy + 409 * v + 128) >>> 8;
        g = (yy - 100 * u - 208 * v + 128) >>> 8;
        b = (yy + 517 * u + 128) >>> 8;
`else
        yy = 256 * int'(y);
        r = (yy + 359 * v + 128) >>> 8;
        g = (yy - 88 * u - 183 * v + 128) >>> 8;
        b = (yy + 454 * u + 128) >>> 8;
`endif
        return {clamp(r), clamp(g), clamp(b)};
    endfunction

    task automatic check(input string name, input exp_t e);
        n_cmp++;
        if (vif.post_img_vsync !== e.vs || vif.post_img_href !== e.hs ||
            vif.post_img_red !== e.r || vif.post_img_green !== e.g ||
            vif.post_img_blue !== e.b) begin
            n_bad++;
            $display("FAIL %s: got vs=%b hs=%b rgb=(%0d,%0d,%0d) want vs=%b hs=%b rgb=(%0d,%0d,%0d) t=%0t",
                     name, vif.post_img_vsync, vif.post_img_href, vif.post_img_red,
                     vif.post_img_green, vif.post_img_blue, e.vs, e.hs, e.r, e.g, e.b, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.vs = 1'b0; e.hs = 1'b0; e.r = '0; e.g = '0; e.b = '0;
        return e;
    endfunction

    // After reset the output stage shows two cycles of flushed (zero) state
    // before the first driven sample arrives.
    task automatic restart_scoreboard();
        q.delete();
        q.push_back(zero_exp());
        q.push_back(zero_exp());
    endtask

    // Drive one cycle; pop and compare the result that emerges 3 clk later.
    task automatic step(input string name, input logic vs, hs, input logic [7:0] y, cb, cr,
                        input logic use_tab, input logic [7:0] tr, tg, tb);
        exp_t e;
        logic [23:0] m;
        vif.per_img_vsync = vs;
        vif.per_img_href  = hs;
        vif.per_img_y     = y;
        vif.per_img_cb    = cb;
        vif.per_img_cr    = cr;
        m = conv(y, cb, cr);
        e.vs = vs;
        e.hs = hs;
        if (!hs) begin
            e.r = '0; e.g = '0; e.b = '0;
        end else if (use_tab) begin
            e.r = tr; e.g = tg; e.b = tb;
        end else begin
            e.r = m[23:16]; e.g = m[15:8]; e.b = m[7:0];
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= 3) check(name, q.pop_front());
    endtask

    task automatic pix(input string name, input logic vs, hs);
        step(name, vs, hs, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    initial begin
`ifdef YCBCR2RGB_LIMITED_RANGE_EN
        vt[0] = '{8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        vt[1] = '{8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
        vt[2] = '{8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130};
        vt[3] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        vt[4] = '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
`else
        vt[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
        vt[1] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};
        vt[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0};
        vt[3] = '{8'd100, 8'd200, 8'd50,  8'd0,   8'd131, 8'd228};
        vt[4] = '{8'd200, 8'd128, 8'd128, 8'd200, 8'd200, 8'd200};
`endif
        vif.per_img_vsync = 1'b0;
        vif.per_img_href  = 1'b0;
        vif.per_img_y     = 8'd0;
        vif.per_img_cb    = 8'd0;
        vif.per_img_cr    = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", zero_exp());
        rst_n = 1'b1;
        restart_scoreboard();

        // Table vectors, back-to-back pixels
        for (int i = 0; i < 5; i++) begin
            step($sformatf("vec%0d", i), 1'b0, 1'b1, vt[i].y, vt[i].cb, vt[i].cr,
                 1'b1, vt[i].r, vt[i].g, vt[i].b);
        end

        // Two 4x3 frames, 2-clk line gaps, second vsync right after last href
        for (int f = 0; f < 2; f++) begin
            pix("frame_vs", 1'b1, 1'b0);
            pix("frame_vs", 1'b1, 1'b0);
            pix("frame_gap", 1'b0, 1'b0);
            for (int l = 0; l < 3; l++) begin
                if (l > 0) begin
                    pix("line_gap", 1'b0, 1'b0);
                    pix("line_gap", 1'b0, 1'b0);
                end
                for (int p = 0; p < 4; p++) pix("frame_pix", 1'b0, 1'b1);
            end
        end
        pix("frame_end", 1'b0, 1'b0);

        // Random sync and data pattern
        for (int i = 0; i < 40; i++) begin
            pix("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-line: in-flight data must be dropped
        for (int i = 0; i < 3; i++) pix("pre_reset", 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_immediate", zero_exp());
        @(posedge clk);
        #1;
        check("reset_hold", zero_exp());
        rst_n = 1'b1;
        restart_scoreboard();
        pix("post_reset_idle", 1'b0, 1'b0);
        pix("post_reset_idle", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pix("post_reset_pix", 1'b0, 1'b1);

        // Drain the pipeline
        for (int i = 0; i < 4; i++) pix("drain", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
